mc_alu: RTL
===========

MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width derived from WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operands and ctrl present.
REQ-006 SHALL have port in_ready  output  1  block accepts a new operation.
REQ-007 SHALL have port input_1  input  WIDTH  operand A.
REQ-008 SHALL have port input_2  input  WIDTH  operand B or shift amount.
REQ-009 SHALL have port ctrl  input  4  opcode.
REQ-010 SHALL have port out_valid  output  1  result, zero and ovf valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  WIDTH  operation result.
REQ-013 SHALL have port zero  output  1  result == 0.
REQ-014 SHALL have port ovf  output  1  signed overflow (ADD/SUB only, else 0).

Function
REQ-015 SHALL decode ctrl: 0000 AND, 0001 OR, 0010 ADD, 0100 SUB, 1000 SLL, 1001 SRL, 1010 SRA, 0111 SLT (signed, result 1 or 0), 0011 MUL (low WIDTH bits of product); any other code gives result 0.
REQ-016 SHALL accept an operation on a clk edge where in_valid && in_ready, latching input_1, input_2 and ctrl.
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-018 IDLE->DONE on accept of any non-MUL op; out_valid asserted the following cycle (latency 1).
REQ-019 IDLE->BUSY on accept of MUL; BUSY runs WIDTH shift-add iterations, one per cycle, then ->DONE; out_valid asserted exactly WIDTH+1 cycles after accept.
REQ-020 DONE: result, zero and ovf SHALL be held stable while out_valid && !out_ready; DONE->IDLE on out_ready.
REQ-021 SHALL ignore in_valid while not in IDLE; back-to-back throughput is one op per 2 cycles minimum.
REQ-022 Shifts SHALL use the full input_2 value: amount >= WIDTH gives 0 for SLL/SRL, all sign bits for SRA.
REQ-023 ovf SHALL be computed from operand and result sign bits for ADD/SUB; carries beyond WIDTH are discarded.
REQ-024 zero SHALL reflect the registered result, including for undefined opcodes (zero = 1).

Reset
REQ-025 While rst_n = 0 at clk edge: state IDLE, out_valid 0, result 0, zero 1, ovf 0, multiplier counters cleared; in_ready SHALL be 0 during the reset cycle.
REQ-026 Reset asserted during BUSY or DONE SHALL abort the operation with no out_valid pulse.

Configuration
REQ-027 Macro MC_ALU_MUL_EN defined: MUL supported per REQ-019.
REQ-028 Macro MC_ALU_MUL_EN undefined: opcode 0011 treated as undefined (1-cycle latency, result 0, zero 1); no multiplier logic instantiated.

Structure
REQ-029 Package mc_alu_pkg SHALL hold the opcode constants, the FSM state typedef and the opcode typedef.
REQ-030 Sub-module mc_alu_mul SHALL contain the iterative shift-add multiplier (start, done, counter), instantiated only under MC_ALU_MUL_EN.

Verification
REQ-031 WIDTH=32, ADD 0x7FFFFFFF + 1 -> result 0x80000000, ovf 1, zero 0, out_valid one cycle after accept.
REQ-032 SUB 5 - 5 -> result 0, zero 1, ovf 0; SLT -1 vs 1 -> result 1.
REQ-033 SRA 0x80000000 by 40 -> 0xFFFFFFFF; SLL 1 by 32 -> 0, zero 1.
REQ-034 MUL 0xFFFF x 0x10001 -> 0xFFFFFFFF after exactly 33 cycles; in_ready 0 throughout; with macro off -> result 0 after 1 cycle.
REQ-035 Hold out_ready 0 for 5 cycles in DONE -> outputs stable, second in_valid ignored; then out_ready 1 -> IDLE next cycle.
REQ-036 rst_n pulled low mid-MUL (cycle 10) -> next cycle IDLE, out_valid 0, result 0, zero 1; no stale completion afterwards.

Source files
------------

// File: rtl/mc_alu_pkg.sv
// Shared opcode and FSM definitions for the multi-cycle ALU.
package mc_alu_pkg;

    localparam int unsigned OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_MUL = 4'b0011,
        OP_SUB = 4'b0100,
        OP_SLT = 4'b0111,
        OP_SLL = 4'b1000,
        OP_SRL = 4'b1001,
        OP_SRA = 4'b1010
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    // Signed overflow from sign bits only; carries out of the MSB are discarded.
    function automatic logic add_sub_ovf(input logic a_msb, input logic b_msb,
                                         input logic r_msb, input logic is_sub);
        if (is_sub)
            return (a_msb != b_msb) && (r_msb != a_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/mc_alu_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
module mc_alu_mul
    import mc_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [SHW-1:0]   cnt_q;
    logic             busy_q;

    // The product presented with done_o already includes the last iteration.
    always_comb begin
        acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
        done_o    = busy_q && (cnt_q == SHW'(WIDTH - 1));
        product_o = acc_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + SHW'(1);
            if (done_o)
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU with valid/ready handshake. Define MC_ALU_MUL_EN to build the
// iterative multiplier; otherwise opcode 0011 behaves as an undefined opcode.
module mc_alu
    import mc_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic [3:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    opcode_e          op;
    logic             accept;
    logic             is_mul_op;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic             shift_big;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign op        = opcode_e'(ctrl);
    assign in_ready  = (state_q == ST_IDLE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

`ifdef MC_ALU_MUL_EN
    assign is_mul_op = (op == OP_MUL);

    mc_alu_mul #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept && is_mul_op),
        .a_i       (input_1),
        .b_i       (input_2),
        .done_o    (mul_done),
        .product_o (mul_product)
    );
`else
    assign is_mul_op   = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    // Any set bit at or above SHW means the amount is >= WIDTH.
    assign shamt     = input_2[SHW-1:0];
    assign shift_big = |input_2[WIDTH-1:SHW];
    assign sum       = input_1 + input_2;
    assign diff      = input_1 - input_2;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND: alu_res = input_1 & input_2;
            OP_OR:  alu_res = input_1 | input_2;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = add_sub_ovf(input_1[WIDTH-1], input_2[WIDTH-1], sum[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = add_sub_ovf(input_1[WIDTH-1], input_2[WIDTH-1], diff[WIDTH-1], 1'b1);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(input_1) < $signed(input_2))};
            OP_SLL: alu_res = shift_big ? '0 : (input_1 << shamt);
            OP_SRL: alu_res = shift_big ? '0 : (input_1 >> shamt);
            OP_SRA: alu_res = shift_big ? {WIDTH{input_1[WIDTH-1]}}
                                        : WIDTH'($signed(input_1) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul_op) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        ovf_d    = alu_ovf;
                    end
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    result_d = mul_product;
                    ovf_d    = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
